// File: rtl/spi_dac_nch.sv
// N-channel SPI mode-0 DAC sequencer: per-channel frame registers, ascending-index
// sweeps of enabled channels, optional LDAC pulse after each sweep.
module spi_dac_nch #(
  parameter int NCH     = 4,
  parameter int FW      = 16,
  parameter int KMAX    = 7,
  parameter int CS_GAP  = 4,
  parameter int LDAC_EN = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           wr_i,
  input  logic [2:0]     wr_ch_i,
  input  logic [FW-1:0]  wr_data_i,
  input  logic [NCH-1:0] ch_en_i,
  input  logic           start_i,
  input  logic           cont_i,
  output logic           mosi_o,
  output logic           sck_o,
  output logic           cs_o,
  output logic           ldac_o,
  output logic           busy_o,
  output logic           eod_o
);

  // state | meaning
  // IDLE  | waiting for start_i / cont_i
  // LOAD  | capture lowest pending channel's frame
  // SHIFT | clock out frame, CS low
  // GAP   | CS high between frames
  // LDAC  | ldac_o low pulse
  // DONE  | eod_o pulse, back to IDLE
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_LDAC, S_DONE} state_t;

  localparam int DW = (KMAX > 0) ? $clog2(KMAX + 1) : 1;
  localparam int BW = $clog2(FW);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DW-1:0] DIV_TC = DW'(KMAX);
  localparam logic [BW-1:0] BIT_TC = BW'(FW - 1);
  localparam logic [GW-1:0] GAP_TC = GW'(CS_GAP - 1);

  state_t         state_q, state_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [FW-1:0]  shreg_q, shreg_d;
  logic [DW-1:0]  div_q, div_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           sck_q, sck_d, cs_q, cs_d, mosi_q, mosi_d, ldac_q, ldac_d;
  logic [FW-1:0]  frame_q [NCH];
  logic [FW-1:0]  cap;
  logic [NCH-1:0] clr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCH; i++) frame_q[i] <= '0;
    end else if (wr_i) begin
      for (int i = 0; i < NCH; i++)
        if (wr_ch_i == 3'(i)) frame_q[i] <= wr_data_i;
    end
  end

  // Descending scan so the lowest pending channel wins.
  always_comb begin
    cap = '0;
    clr = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        cap    = frame_q[i];
        clr    = '0;
        clr[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    ldac_d  = ldac_q;
    case (state_q)
      S_IDLE: begin
        if (start_i || cont_i) begin
          mask_d  = ch_en_i;
          state_d = (ch_en_i == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        shreg_d = cap;
        mask_d  = mask_q & ~clr;
        cs_d    = 1'b0;
        sck_d   = 1'b0;
        mosi_d  = cap[FW-1];
        div_d   = DIV_TC;
        bit_d   = BIT_TC;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else begin
          div_d = DIV_TC;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else if (bit_q != '0) begin
            sck_d   = 1'b0;
            bit_d   = bit_q - 1'b1;
            shreg_d = shreg_q << 1;
            mosi_d  = shreg_q[FW-2];
          end else begin
            sck_d   = 1'b0;
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            gap_d   = GAP_TC;
            state_d = (CS_GAP == 1 && mask_q != '0) ? S_LOAD : S_GAP;
          end
        end
      end
      S_GAP: begin
        // The LOAD cycle counts as the last CS-high cycle when another frame follows.
        if ((mask_q != '0) && (gap_q <= GW'(1))) begin
          state_d = S_LOAD;
        end else if (gap_q == '0) begin
          if (LDAC_EN != 0) begin
            ldac_d  = 1'b0;
            div_d   = DIV_TC;
            state_d = S_LDAC;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_LDAC: begin
        if (div_q == '0) begin
          ldac_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      ldac_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      ldac_q  <= ldac_d;
    end
  end

  assign mosi_o = mosi_q;
  assign sck_o  = sck_q;
  assign cs_o   = cs_q;
  assign ldac_o = ldac_q;
  assign busy_o = (state_q != S_IDLE);
  assign eod_o  = (state_q == S_DONE);

endmodule

// File: tb/tb_spi_dac_nch.sv
// Bench for spi_dac_nch: queue-based waveform model checked every cycle, plus
// decoded-frame and timing checks with hand-computed literals.
module tb_spi_dac_nch;
  localparam int NCH = 4, FW = 16, KMAX = 7, CS_GAP = 4, H = KMAX + 1;

  logic clk_i = 1'b0, rst_i = 1'b1, wr_i = 1'b0, start_i = 1'b0, cont_i = 1'b0;
  logic [2:0] wr_ch_i = '0;
  logic [FW-1:0] wr_data_i = '0;
  logic [NCH-1:0] ch_en_i = '0;
  logic mosi_o, sck_o, cs_o, ldac_o, busy_o, eod_o;
  logic n_mosi, n_sck, n_cs, n_ldac, n_busy, n_eod;

  spi_dac_nch #(.NCH(NCH), .FW(FW), .KMAX(KMAX), .CS_GAP(CS_GAP), .LDAC_EN(1)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_i(wr_i), .wr_ch_i(wr_ch_i), .wr_data_i(wr_data_i),
    .ch_en_i(ch_en_i), .start_i(start_i), .cont_i(cont_i), .mosi_o(mosi_o), .sck_o(sck_o),
    .cs_o(cs_o), .ldac_o(ldac_o), .busy_o(busy_o), .eod_o(eod_o));

  spi_dac_nch #(.NCH(NCH), .FW(FW), .KMAX(KMAX), .CS_GAP(CS_GAP), .LDAC_EN(0)) u_dut_nl (
    .clk_i(clk_i), .rst_i(rst_i), .wr_i(wr_i), .wr_ch_i(wr_ch_i), .wr_data_i(wr_data_i),
    .ch_en_i(ch_en_i), .start_i(start_i), .cont_i(cont_i), .mosi_o(n_mosi), .sck_o(n_sck),
    .cs_o(n_cs), .ldac_o(n_ldac), .busy_o(n_busy), .eod_o(n_eod));

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_err = 0;

  // ---------------- waveform model ----------------
  typedef struct packed {
    logic cs, sck, mosi, ldac, busy, eod, load;
    logic [2:0] ch;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int chq[$];
  logic [FW-1:0] mfr [NCH];

  function automatic exp_t mk(input logic cs, input logic sck, input logic mosi,
                              input logic ldac, input logic busy, input logic eod);
    exp_t e;
    e.cs = cs; e.sck = sck; e.mosi = mosi; e.ldac = ldac; e.busy = busy; e.eod = eod;
    e.load = 1'b0; e.ch = '0;
    return e;
  endfunction

  function automatic void push_load(input int ch);
    exp_t e;
    e = mk(1, 0, 0, 1, 1, 0);
    e.load = 1'b1;
    e.ch = 3'(ch);
    q.push_back(e);
  endfunction

  // Expected waveform for one frame and what follows it.
  function automatic void expand(input int ch);
    logic [FW-1:0] f;
    f = mfr[ch];
    for (int b = FW - 1; b >= 0; b--) begin
      for (int k = 0; k < H; k++) q.push_back(mk(0, 0, f[b], 1, 1, 0));
      for (int k = 0; k < H; k++) q.push_back(mk(0, 1, f[b], 1, 1, 0));
    end
    if (chq.size() > 0) begin
      for (int k = 0; k < CS_GAP - 1; k++) q.push_back(mk(1, 0, 0, 1, 1, 0));
      push_load(chq.pop_front());
    end else begin
      for (int k = 0; k < CS_GAP; k++) q.push_back(mk(1, 0, 0, 1, 1, 0));
      for (int k = 0; k < H; k++) q.push_back(mk(1, 0, 0, 0, 1, 0));
      q.push_back(mk(1, 0, 0, 1, 1, 1));
    end
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q.delete();
      chq.delete();
      cur = mk(1, 0, 0, 1, 0, 0);
      for (int i = 0; i < NCH; i++) mfr[i] = '0;
    end else begin
      if (wr_i && int'(wr_ch_i) < NCH) mfr[int'(wr_ch_i)] = wr_data_i;
      if (!cur.busy && (start_i || cont_i)) begin
        for (int i = 0; i < NCH; i++) if (ch_en_i[i]) chq.push_back(i);
        if (chq.size() == 0) q.push_back(mk(1, 0, 0, 1, 1, 1));
        else push_load(chq.pop_front());
      end
      if (q.size() > 0) begin
        cur = q.pop_front();
        if (cur.load) expand(int'(cur.ch));
      end else begin
        cur = mk(1, 0, 0, 1, 0, 0);
      end
    end
  end

  always @(negedge clk_i) begin
    n_cmp++;
    if ({cs_o, sck_o, mosi_o, ldac_o, busy_o, eod_o} !==
        {cur.cs, cur.sck, cur.mosi, cur.ldac, cur.busy, cur.eod}) begin
      n_err++;
      $display("FAIL pins t=%0t cs/sck/mosi/ldac/busy/eod got %b required %b", $time,
               {cs_o, sck_o, mosi_o, ldac_o, busy_o, eod_o},
               {cur.cs, cur.sck, cur.mosi, cur.ldac, cur.busy, cur.eod});
    end
    n_cmp++;
    if (n_ldac !== 1'b1) begin
      n_err++;
      $display("FAIL ldac_disabled t=%0t got %b required 1", $time, n_ldac);
    end
  end

  // ---------------- bus monitor ----------------
  logic [FW-1:0] sh;
  logic prev_sck, prev_cs, had_rise;
  int low_len, high_len, ldac_len, blow, eod_cnt, cs_fall;
  logic [FW-1:0] dec_q[$];
  int csl_q[$], gap_q[$], ldac_q[$], idle_q[$];

  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_sck = 0; prev_cs = 1; had_rise = 0; sh = '0;
      low_len = 0; high_len = 0; ldac_len = 0; blow = 0;
    end else begin
      if (!prev_sck && sck_o && !cs_o) sh = {sh[FW-2:0], mosi_o};
      if (prev_cs && !cs_o) begin
        cs_fall++;
        if (busy_o && had_rise) gap_q.push_back(high_len);
        low_len = 0;
      end
      if (!prev_cs && cs_o) begin
        dec_q.push_back(sh);
        csl_q.push_back(low_len);
        high_len = 0;
        had_rise = 1;
      end
      if (!cs_o) low_len++; else high_len++;
      if (!busy_o) had_rise = 0;
      if (!ldac_o) ldac_len++;
      else if (ldac_len > 0) begin ldac_q.push_back(ldac_len); ldac_len = 0; end
      if (!busy_o) blow++;
      else if (blow > 0) begin idle_q.push_back(blow); blow = 0; end
      if (eod_o) eod_cnt++;
      prev_sck = sck_o;
      prev_cs = cs_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check(input string name, input int got, input int req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  task automatic clr_mon();
    dec_q.delete(); csl_q.delete(); gap_q.delete(); ldac_q.delete(); idle_q.delete();
    eod_cnt = 0; cs_fall = 0;
  endtask

  task automatic wr(input int ch, input logic [FW-1:0] d);
    wr_i = 1; wr_ch_i = 3'(ch); wr_data_i = d;
    tick(1);
    wr_i = 0;
  endtask

  task automatic start_sweep(input logic [NCH-1:0] m);
    ch_en_i = m; start_i = 1;
    tick(1);
    start_i = 0;
  endtask

  task automatic wait_eod(input int budget);
    int k;
    k = 0;
    while (!eod_o && k < budget) begin tick(1); k++; end
    n_cmp++;
    if (!eod_o) begin
      n_err++;
      $display("FAIL eod_timeout got no eod within %0d cycles", budget);
    end
  endtask

  initial begin
    cur = mk(1, 0, 0, 1, 0, 0);
    eod_cnt = 0; cs_fall = 0;
    tick(3);
    check("reset_pins", {cs_o, sck_o, mosi_o, ldac_o, busy_o, eod_o}, 6'b100100);
    rst_i = 0;
    tick(2);

    // full sweep, all four channels
    wr(0, 16'h3133); wr(1, 16'hB266); wr(2, 16'h3FFF); wr(3, 16'hB000);
    wr(5, 16'hDEAD);
    clr_mon();
    start_sweep(4'hF);
    check("cs_before_latency", cs_o, 1);
    check("busy_at_start", busy_o, 1);
    tick(1);
    check("cs_fall_latency", cs_o, 0);
    tick(300);
    start_sweep(4'h0);
    wait_eod(3000);
    tick(3);
    check("busy_after_ignored_start", busy_o, 0);
    check("t2_nframes", dec_q.size(), 4);
    if (dec_q.size() == 4) begin
      check("t2_f0", dec_q[0], 16'h3133);
      check("t2_f1", dec_q[1], 16'hB266);
      check("t2_f2", dec_q[2], 16'h3FFF);
      check("t2_f3", dec_q[3], 16'hB000);
      check("t2_cs_len0", csl_q[0], 256);
      check("t2_cs_len3", csl_q[3], 256);
    end
    check("t2_ngaps", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      check("t2_gap0", gap_q[0], 4);
      check("t2_gap2", gap_q[2], 4);
    end
    check("t2_nldac", ldac_q.size(), 1);
    if (ldac_q.size() == 1) check("t2_ldac_len", ldac_q[0], 8);
    check("t2_eod_cnt", eod_cnt, 1);

    // sparse mask, then empty mask
    clr_mon();
    start_sweep(4'b0101);
    wait_eod(3000);
    tick(3);
    check("t3_nframes", dec_q.size(), 2);
    if (dec_q.size() == 2) begin
      check("t3_f0", dec_q[0], 16'h3133);
      check("t3_f1", dec_q[1], 16'h3FFF);
    end
    clr_mon();
    start_sweep(4'b0000);
    check("t3_eod_latency", eod_o, 1);
    tick(3);
    check("t3_no_cs", cs_fall, 0);
    check("t3_eod_cnt", eod_cnt, 1);

    // write during in-flight frame
    clr_mon();
    start_sweep(4'b0010);
    tick(60);
    wr(1, 16'h1234);
    wait_eod(3000);
    tick(3);
    check("t4_nframes_a", dec_q.size(), 1);
    if (dec_q.size() == 1) check("t4_old", dec_q[0], 16'hB266);
    clr_mon();
    start_sweep(4'b0010);
    wait_eod(3000);
    tick(3);
    check("t4_nframes_b", dec_q.size(), 1);
    if (dec_q.size() == 1) check("t4_new", dec_q[0], 16'h1234);

    // continuous mode, then drop cont mid-sweep
    clr_mon();
    ch_en_i = 4'b0001;
    cont_i = 1;
    wait_eod(1000); tick(1);
    wait_eod(1000); tick(100);
    cont_i = 0;
    wait_eod(1000);
    tick(20);
    check("t5_busy_idle", busy_o, 0);
    check("t5_eod_cnt", eod_cnt, 3);
    check("t5_nidle", (idle_q.size() >= 2) ? 1 : 0, 1);
    if (idle_q.size() >= 2) begin
      check("t5_idle_a", idle_q[idle_q.size() - 1], 1);
      check("t5_idle_b", idle_q[idle_q.size() - 2], 1);
    end

    // asynchronous reset mid-frame clears frame registers
    clr_mon();
    start_sweep(4'hF);
    tick(40);
    @(posedge clk_i);
    #1 rst_i = 1;
    #1 check("t1_async_reset", {cs_o, sck_o, mosi_o, ldac_o, busy_o, eod_o}, 6'b100100);
    tick(2);
    rst_i = 0;
    tick(2);
    clr_mon();
    start_sweep(4'hF);
    wait_eod(3000);
    tick(3);
    check("t1_nframes", dec_q.size(), 4);
    for (int i = 0; i < dec_q.size(); i++) check("t1_frame_zero", dec_q[i], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish required finish by 2ms");
    $fatal(1, "timeout");
  end

endmodule
